// File: rtl/alu_exec.sv
// Multi-cycle ALU execution unit: single-cycle logic/arith ops plus an
// 8-iteration shift-add multiplier, with a registered write-back stage.
module alu_exec #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [3:0]            i_op,
    input  logic [ADDR_WIDTH-1:0] i_rd,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [ADDR_WIDTH-1:0] o_wb_reg,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    output logic                  o_done,
    output logic                  o_zero,
    output logic                  o_carry
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_PASS = 4'd8;
    localparam logic [3:0] ITERS   = 4'(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rd_q, rd_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    nop_q, nop_d;
    logic                    zero_q, zero_d;
    logic                    carry_q, carry_d;

    logic [DATA_WIDTH:0]     sum_w;
    logic [DATA_WIDTH:0]     diff_w;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic                    alu_carry;
    logic                    accept;

    assign sum_w  = {1'b0, i_a} + {1'b0, i_b};
    assign diff_w = {1'b0, i_a} - {1'b0, i_b};
    assign accept = i_valid && (state_q == S_IDLE);

    // Single-cycle datapath works straight off the operand ports at accept.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (i_op)
            OP_ADD:  begin alu_res = sum_w[DATA_WIDTH-1:0];  alu_carry = sum_w[DATA_WIDTH];  end
            OP_SUB:  begin alu_res = diff_w[DATA_WIDTH-1:0]; alu_carry = diff_w[DATA_WIDTH]; end
            OP_AND:  alu_res = i_a & i_b;
            OP_OR:   alu_res = i_a | i_b;
            OP_XOR:  alu_res = i_a ^ i_b;
            OP_SHL:  begin alu_res = i_a << 1; alu_carry = i_a[DATA_WIDTH-1]; end
            OP_SHR:  begin alu_res = i_a >> 1; alu_carry = i_a[0]; end
            OP_PASS: alu_res = i_a;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        nop_d    = nop_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rd_d  = i_rd;
                    a_d   = i_a;
                    b_d   = i_b;
                    acc_d = '0;
                    cnt_d = '0;
                    if (i_op == OP_MUL) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d  = S_WB;
                        result_d = alu_res;
                        nop_d    = (i_op > OP_PASS);
                        if (i_op <= OP_PASS) begin
                            zero_d  = (alu_res == '0);
                            carry_d = alu_carry;
                        end
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == ITERS) begin
                    state_d  = S_WB;
                    result_d = acc_q[DATA_WIDTH-1:0];
                    nop_d    = 1'b0;
                    zero_d   = (acc_q[DATA_WIDTH-1:0] == '0);
                    carry_d  = |acc_q[2*DATA_WIDTH-1:DATA_WIDTH];
                end else begin
                    // Multiplier consumed LSB-first; b shifts down, a is weighted by the count.
                    if (b_q[0]) begin
                        acc_d = acc_q + ({{DATA_WIDTH{1'b0}}, a_q} << cnt_q);
                    end
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q  <= S_IDLE;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            nop_q    <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            nop_q    <= nop_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    assign o_ready   = (state_q == S_IDLE);
    assign o_done    = (state_q == S_WB);
    assign o_wb_reg  = (state_q == S_WB && !nop_q) ? rd_q : '0;
    assign o_wb_data = (state_q == S_WB) ? result_q : '0;
    assign o_zero    = zero_q;
    assign o_carry   = carry_q;

endmodule

// File: tb/tb_alu_exec.sv
// Randomized self-checking bench for alu_exec against an arithmetic reference model.
module tb_alu_exec;

    logic       i_CLK = 1'b0;
    logic       i_RSTn;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_op;
    logic [4:0] i_rd;
    logic [7:0] i_a, i_b;
    logic [4:0] o_wb_reg;
    logic [7:0] o_wb_data;
    logic       o_done, o_zero, o_carry;

    int   total = 0;
    int   bad   = 0;
    logic exp_zero  = 1'b0;
    logic exp_carry = 1'b0;

    alu_exec #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .i_CLK     (i_CLK),
        .i_RSTn    (i_RSTn),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op      (i_op),
        .i_rd      (i_rd),
        .i_a       (i_a),
        .i_b       (i_b),
        .o_wb_reg  (o_wb_reg),
        .o_wb_data (o_wb_data),
        .o_done    (o_done),
        .o_zero    (o_zero),
        .o_carry   (o_carry)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode definitions.
    function automatic void ref_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] r, output logic c, output logic nop);
        int ia = int'(a);
        int ib = int'(b);
        int full;
        r = 8'd0; c = 1'b0; nop = 1'b0;
        case (op)
            4'd0: begin full = ia + ib; r = 8'(full % 256); c = (full > 255); end
            4'd1: begin full = ia - ib + 256; r = 8'(full % 256); c = (ia < ib); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin full = ia * 2; r = 8'(full % 256); c = (ia >= 128); end
            4'd6: begin r = 8'(ia / 2); c = (ia % 2 == 1); end
            4'd7: begin full = ia * ib; r = 8'(full % 256); c = (full / 256 != 0); end
            4'd8: r = a;
            default: nop = 1'b1;
        endcase
    endfunction

    // Issue one operation from a negedge; scramble inputs and pulse i_valid while busy.
    task automatic do_op(input logic [3:0] op, input logic [4:0] rd, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       c, nop;
        int         n;
        bit         seen;
        ref_op(op, a, b, r, c, nop);
        check("ready_before", o_ready, 1);
        i_valid = 1'b1; i_op = op; i_rd = rd; i_a = a; i_b = b;
        @(posedge i_CLK);
        #1;
        i_valid = 1'b0; i_a = 8'($urandom); i_b = 8'($urandom); i_rd = 5'($urandom);
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge i_CLK);
            n++;
            if (o_done) begin
                seen = 1;
            end else begin
                i_valid = 1'($urandom_range(0, 1));
                i_a = 8'($urandom); i_b = 8'($urandom); i_op = 4'($urandom);
            end
        end
        i_valid = 1'b0;
        check("done_seen", seen, 1);
        if (seen) begin
            check("latency", n, (op == 4'd7) ? 10 : 1);
            check("wb_reg", o_wb_reg, nop ? 5'd0 : rd);
            if (!nop) begin
                check("wb_data", o_wb_data, r);
                exp_zero  = (r == 8'd0);
                exp_carry = c;
            end
            check("zero", o_zero, exp_zero);
            check("carry", o_carry, exp_carry);
            $display("op=%0d rd=%0d a=%0d b=%0d -> wb_reg=%0d data=%0h z=%0b c=%0b cycles=%0d",
                     op, rd, a, b, o_wb_reg, o_wb_data, o_zero, o_carry, n);
        end
        @(negedge i_CLK);
        check("done_after", o_done, 0);
        check("wb_reg_after", o_wb_reg, 0);
        check("ready_after", o_ready, 1);
    endtask

    initial begin
        i_RSTn = 1'b0; i_valid = 1'b0; i_op = '0; i_rd = '0; i_a = '0; i_b = '0;
        repeat (3) @(negedge i_CLK);
        check("rst_ready", o_ready, 1);
        check("rst_done", o_done, 0);
        check("rst_wb_reg", o_wb_reg, 0);
        check("rst_wb_data", o_wb_data, 0);
        check("rst_zero", o_zero, 0);
        check("rst_carry", o_carry, 0);
        i_RSTn = 1'b1;

        do_op(4'd0, 5'd3, 8'd10, 8'd5);
        do_op(4'd1, 5'd4, 8'd5, 8'd10);
        do_op(4'd0, 5'd9, 8'd200, 8'd56);
        do_op(4'd7, 5'd7, 8'd10, 8'd5);
        do_op(4'd12, 5'd5, 8'd1, 8'd1);
        do_op(4'd0, 5'd0, 8'd3, 8'd4);
        do_op(4'd7, 5'd8, 8'd20, 8'd13);

        // Abort a multiply mid-way with an asynchronous reset.
        i_valid = 1'b1; i_op = 4'd7; i_rd = 5'd6; i_a = 8'd255; i_b = 8'd255;
        @(posedge i_CLK);
        #1 i_valid = 1'b0;
        repeat (4) @(negedge i_CLK);
        #2 i_RSTn = 1'b0;
        #1;
        check("abort_ready", o_ready, 1);
        check("abort_wb_reg", o_wb_reg, 0);
        check("abort_done", o_done, 0);
        check("abort_zero", o_zero, 0);
        check("abort_carry", o_carry, 0);
        exp_zero = 1'b0; exp_carry = 1'b0;
        @(negedge i_CLK);
        i_RSTn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge i_CLK);
            check("abort_no_done", o_done, 0);
            check("abort_no_wb", o_wb_reg, 0);
        end
        $display("reset abort of op=7 rd=6: no write-back observed");

        for (int t = 0; t < 200; t++) begin
            logic [3:0] op;
            op = (t % 5 == 0) ? 4'd7 : 4'($urandom_range(0, 15));
            do_op(op, 5'($urandom), 8'($urandom), 8'((t % 7 == 0) ? 0 : $urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: DATA_WIDTH, 8, operand/result width.
REQ-002 Parameter: ADDR_WIDTH, 5, register address width.
REQ-003 i_CLK  in  1  clock; all state changes on rising edge.
REQ-004 i_RSTn  in  1  reset, asynchronous, active-low.
REQ-005 i_valid  in  1  operation request; accepted when i_valid && o_ready at a rising edge.
REQ-006 o_ready  out  1  high only in IDLE.
REQ-007 i_op  in  4  opcode.
REQ-008 i_rd  in  ADDR_WIDTH  destination register.
REQ-009 i_a, i_b  in  DATA_WIDTH each  operands, driven from the register file read ports.
REQ-010 o_wb_reg  out  ADDR_WIDTH  write-back address to the register file write port; 0 means no write.
REQ-011 o_wb_data  out  DATA_WIDTH  write-back data.
REQ-012 o_done  out  1  one-cycle completion pulse.
REQ-013 o_zero, o_carry  out  1 each  registered status flags.

Function
REQ-014 Opcodes: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 SHL by 1, 6 SHR logical by 1, 7 MUL (unsigned, low byte), 8 PASS (result=a), 9-15 NOP.
REQ-015 i_op, i_rd, i_a and i_b are latched at acceptance; later input changes have no effect on the operation in flight.
REQ-016 FSM states: IDLE, EXEC, WB.
- IDLE -> WB on accept for every opcode except MUL.
- IDLE -> EXEC on accept of MUL.
- EXEC -> WB after exactly 8 iterations.
- WB -> IDLE unconditionally.
REQ-017 Latency: single-cycle ops reach WB in the cycle after acceptance; MUL reaches WB 9 cycles after acceptance.
REQ-018 MUL is shift-add: one multiplier bit per EXEC cycle, using a 2*DATA_WIDTH accumulator and a 4-bit iteration counter.
REQ-019 In WB: o_wb_reg=latched rd, o_wb_data=result, o_done=1.
REQ-020 Outside WB: o_wb_reg=0, o_wb_data=0, o_done=0.
REQ-021 NOP: passes through WB with o_done=1 but o_wb_reg=0; flags unchanged.
REQ-022 rd=0: WB proceeds normally, o_wb_reg=0, so no register is written; flags update.
REQ-023 Flags load at the edge entering WB and hold until the next non-NOP WB.
- zero = (result==0).
REQ-024 Carry rules:
- ADD: carry-out of bit DATA_WIDTH-1.
- SUB: borrow (a<b).
- SHL: a[7].
- SHR: a[0].
- MUL: any nonzero bit in product[15:8].
- AND/OR/XOR/PASS: 0.
REQ-025 All arithmetic is modulo 2^DATA_WIDTH; no saturation.
REQ-026 i_valid while o_ready=0 is ignored, with no queuing; the requester holds i_valid until accepted.
REQ-027 Back-to-back operation: a new request is accepted in the IDLE cycle following WB, at a maximum of one operation per 2 cycles.

Reset
REQ-028 Asserting i_RSTn low asynchronously forces state IDLE and sets o_ready=1, o_wb_reg=0, o_wb_data=0, o_done=0, o_zero=0, o_carry=0, iteration counter=0, accumulator=0.
REQ-029 Reset during EXEC or WB aborts the operation: no write-back and no o_done pulse, either during or after reset.
REQ-030 After i_RSTn is released, the first accept is possible at the first rising edge.

Verification
REQ-031 ADD a=10 b=5 rd=3 -> next cycle o_wb_reg=3, o_wb_data=15, o_done=1, zero=0, carry=0; o_wb_reg=0 the following cycle.
REQ-032 SUB a=5 b=10 rd=4 -> o_wb_data=0xFB, carry=1, zero=0; ADD a=200 b=56 -> o_wb_data=0x00, zero=1, carry=1.
REQ-033 MUL a=10 b=5 rd=7 -> o_ready=0 for 9 cycles, then WB with o_wb_data=50, carry=0; MUL a=20 b=13 -> o_wb_data=0x04, carry=1.
REQ-034 During MUL EXEC, toggle i_a/i_b and pulse i_valid -> result unchanged, no extra accept, exactly one o_done.
REQ-035 Assert reset at EXEC iteration 4 -> o_wb_reg stays 0, no o_done, o_ready=1 during reset, flags=0.
REQ-036 Opcode 12 rd=5, and ADD rd=0 -> o_done=1 with o_wb_reg=0 in both cases; flags unchanged after the NOP, updated after the ADD.
